// File: rtl/acl_tuple_extractor.sv
// acl_tuple_extractor: pulls the IPv4 5-tuple out of a 32-bit Ethernet word
// stream. It holds one result for the ACL rule-match stage behind a
// valid/ready handshake. Payload words are accepted and dropped.
module acl_tuple_extractor #(
    parameter int          C_TDATA_WIDTH  = 32,
    parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_rxd_tvalid,
    input  logic                     i_rxd_tlast,
    input  logic [C_TDATA_WIDTH-1:0] i_rxd_tdata,
    output logic                     o_rxd_tready,
    output logic                     o_tuple_valid,
    input  logic                     i_tuple_ready,
    output logic [31:0]              o_src_ip,
    output logic [31:0]              o_dst_ip,
    output logic [7:0]               o_protocol,
    output logic [15:0]              o_src_port,
    output logic [15:0]              o_dst_port,
    output logic                     o_hdr_err
);

    // state  | meaning
    // S_HDR  | walking header words 0..9, result not yet launched
    // S_DRAIN| header done, discarding payload until tlast
    typedef enum logic {S_HDR, S_DRAIN} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        rdy_en;
    logic        err;
    logic [7:0]  proto;
    logic [31:0] sip, dip;
    logic [15:0] sport;

    logic [7:0]  proto_c;
    logic [31:0] sip_c, dip_c;
    logic [15:0] sport_c, dport_c;
    logic        err_c;
    logic        xfer, launch, runt, is_l4;

    assign xfer   = i_rxd_tvalid && o_rxd_tready;
    assign runt   = i_rxd_tlast && (cnt < 4'd9);
    assign launch = xfer && (state == S_HDR) && ((cnt == 4'd9) || runt);
    assign is_l4  = (proto_c == 8'd6) || (proto_c == 8'd17);

    // Header fields as they stand after the current word; lets a launch on
    // w9 or a runt tlast include the word being transferred.
    always_comb begin
        proto_c = proto;
        sip_c   = sip;
        dip_c   = dip;
        sport_c = sport;
        dport_c = 16'h0000;
        err_c   = err;
        if (xfer && state == S_HDR) begin
            case (cnt)
                4'd3: err_c = err || (i_rxd_tdata[31:16] != ETHERTYPE_IPV4)
                                  || (i_rxd_tdata[15:8] != 8'h45);
                4'd5: proto_c = i_rxd_tdata[7:0];
                4'd6: sip_c[31:16] = i_rxd_tdata[15:0];
                4'd7: begin
                    sip_c[15:0]  = i_rxd_tdata[31:16];
                    dip_c[31:16] = i_rxd_tdata[15:0];
                end
                4'd8: begin
                    dip_c[15:0] = i_rxd_tdata[31:16];
                    sport_c     = i_rxd_tdata[15:0];
                end
                4'd9: dport_c = i_rxd_tdata[31:16];
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_HDR;
        else     state <= state_nxt;
    end

    // Next-state: leave for DRAIN after w9 unless it ended the frame
    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR:   if (xfer && !i_rxd_tlast && cnt == 4'd9) state_nxt = S_DRAIN;
            S_DRAIN: if (xfer && i_rxd_tlast)                 state_nxt = S_HDR;
            default: state_nxt = S_HDR;
        endcase
    end

    // Ready: word 0 of a frame waits while an unaccepted result is held
    always_comb begin
        o_rxd_tready = rdy_en;
        if (state == S_HDR && cnt == 4'd0 && o_tuple_valid && !i_tuple_ready)
            o_rxd_tready = 1'b0;
    end

    // Word counter and per-frame working registers, cleared at every tlast
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en <= 1'b0;
            cnt    <= 4'd0;
            err    <= 1'b0;
            proto  <= 8'h00;
            sip    <= 32'h0;
            dip    <= 32'h0;
            sport  <= 16'h0;
        end else begin
            rdy_en <= 1'b1;
            if (xfer) begin
                if (i_rxd_tlast) begin
                    cnt   <= 4'd0;
                    err   <= 1'b0;
                    proto <= 8'h00;
                    sip   <= 32'h0;
                    dip   <= 32'h0;
                    sport <= 16'h0;
                end else begin
                    if (cnt != 4'd10) cnt <= cnt + 4'd1;
                    err   <= err_c;
                    proto <= proto_c;
                    sip   <= sip_c;
                    dip   <= dip_c;
                    sport <= sport_c;
                end
            end
        end
    end

    // Result register: load on launch, drop valid after a handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_tuple_valid <= 1'b0;
            o_src_ip      <= 32'h0;
            o_dst_ip      <= 32'h0;
            o_protocol    <= 8'h00;
            o_src_port    <= 16'h0;
            o_dst_port    <= 16'h0;
            o_hdr_err     <= 1'b0;
        end else if (launch) begin
            o_tuple_valid <= 1'b1;
            o_src_ip      <= sip_c;
            o_dst_ip      <= dip_c;
            o_protocol    <= proto_c;
            o_src_port    <= is_l4 ? sport_c : 16'h0;
            o_dst_port    <= is_l4 ? dport_c : 16'h0;
            o_hdr_err     <= err_c || runt;
        end else if (o_tuple_valid && i_tuple_ready) begin
            o_tuple_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acl_tuple_extractor.sv
// Bench for acl_tuple_extractor: byte-level frame builder, byte-level result
// model, a scoreboard queue checked at every handshake, and literal pins.
module tb_acl_tuple_extractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rxd_tvalid = 1'b0;
    logic        i_rxd_tlast = 1'b0;
    logic [31:0] i_rxd_tdata = 32'h0;
    logic        o_rxd_tready;
    logic        o_tuple_valid;
    logic        i_tuple_ready = 1'b1;
    logic [31:0] o_src_ip, o_dst_ip;
    logic [7:0]  o_protocol;
    logic [15:0] o_src_port, o_dst_port;
    logic        o_hdr_err;

    acl_tuple_extractor dut (
        .clk(clk), .rst(rst),
        .i_rxd_tvalid(i_rxd_tvalid), .i_rxd_tlast(i_rxd_tlast),
        .i_rxd_tdata(i_rxd_tdata), .o_rxd_tready(o_rxd_tready),
        .o_tuple_valid(o_tuple_valid), .i_tuple_ready(i_tuple_ready),
        .o_src_ip(o_src_ip), .o_dst_ip(o_dst_ip), .o_protocol(o_protocol),
        .o_src_port(o_src_port), .o_dst_port(o_dst_port), .o_hdr_err(o_hdr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sip, dip;
        logic [7:0]  proto;
        logic [15:0] sp, dp;
        logic        err;
    } res_t;

    res_t        expq[$];
    logic [7:0]  b[0:255];
    logic [31:0] fw[0:63];
    int          fn;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [104:0] dut_fields();
        return {o_src_ip, o_dst_ip, o_protocol, o_src_port, o_dst_port, o_hdr_err};
    endfunction

    task automatic mk_frame(input logic [15:0] et, input logic [7:0] vihl, input logic [7:0] proto,
                            input logic [31:0] sip, input logic [31:0] dip,
                            input logic [15:0] sp, input logic [15:0] dp, input int n);
        for (int i = 0; i < 256; i++) b[i] = 8'(i * 7 + 3);
        {b[12], b[13]} = et;
        b[14] = vihl;
        b[22] = 8'd64;
        b[23] = proto;
        {b[26], b[27], b[28], b[29]} = sip;
        {b[30], b[31], b[32], b[33]} = dip;
        {b[34], b[35]} = sp;
        {b[36], b[37]} = dp;
        for (int w = 0; w < 64; w++) fw[w] = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
        fn = n;
    endtask

    // A header byte reaches the result only if its word was transferred.
    function automatic logic [7:0] vis(input int i);
        return (i < 4 * fn) ? b[i] : 8'h00;
    endfunction

    function automatic res_t model();
        res_t r;
        r.sip   = {vis(26), vis(27), vis(28), vis(29)};
        r.dip   = {vis(30), vis(31), vis(32), vis(33)};
        r.proto = vis(23);
        if (r.proto == 8'd6 || r.proto == 8'd17) begin
            r.sp = {vis(34), vis(35)};
            r.dp = {vis(36), vis(37)};
        end else begin
            r.sp = 16'h0;
            r.dp = 16'h0;
        end
        if (fn < 10) r.err = 1'b1;
        else         r.err = ({b[12], b[13]} != 16'h0800) || (b[14] != 8'h45);
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the word's transfer edge.
    task automatic send_word(input logic [31:0] d, input logic last);
        logic ok;
        int   budget;
        i_rxd_tvalid = 1'b1;
        i_rxd_tdata  = d;
        i_rxd_tlast  = last;
        budget = 0;
        do begin
            #1 ok = o_rxd_tready;
            @(posedge clk);
            @(negedge clk);
            budget++;
        end while (!ok && budget < 200);
        if (!ok) chk("word_timeout", 128'(1), 128'(0));
    endtask

    task automatic send_frame();
        int li;
        expq.push_back(model());
        li = (fn >= 10) ? 9 : fn - 1;
        for (int w = 0; w < fn; w++) begin
            send_word(fw[w], w == fn - 1);
            if (w == li) chk("launch_latency", 128'(o_tuple_valid), 128'(1));
        end
        i_rxd_tvalid = 1'b0;
        i_rxd_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        #3 rst = 1'b1;
        #1 chk("reset_outputs", {22'h0, dut_fields(), o_tuple_valid}, 128'(0));
        chk("reset_tready", 128'(o_rxd_tready), 128'(0));
        expq.delete();
        i_rxd_tvalid = 1'b0;
        i_rxd_tlast  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard: fields held while a result waits; pop model at each handshake.
    initial begin : compare
        logic        pv, phs;
        logic [104:0] pf;
        res_t        r;
        pv = 1'b0; phs = 1'b0; pf = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pv = 1'b0;
                phs = 1'b0;
                continue;
            end
            if (o_tuple_valid && pv && !phs) chk("fields_stable", 128'(dut_fields()), 128'(pf));
            if (o_tuple_valid && i_tuple_ready) begin
                if (expq.size() == 0) chk("unexpected_result", 128'(1), 128'(0));
                else begin
                    r = expq.pop_front();
                    chk("tuple", 128'(dut_fields()), 128'({r.sip, r.dip, r.proto, r.sp, r.dp, r.err}));
                end
            end
            pv  = o_tuple_valid;
            phs = o_tuple_valid && i_tuple_ready;
            pf  = dut_fields();
        end
    end

    initial begin
        #1 chk("reset_state", {22'h0, dut_fields(), o_tuple_valid}, 128'(0));
        chk("reset_tready", 128'(o_rxd_tready), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic TCP, 16 words
        mk_frame(16'h0800, 8'h45, 8'd6, 32'hC0A8010A, 32'h0A000005, 16'h1F90, 16'h0050, 16);
        send_frame();
        chk("tcp_lit", 128'({o_src_ip, o_dst_ip, o_protocol, o_src_port, o_dst_port, o_hdr_err}),
            128'({32'hC0A8010A, 32'h0A000005, 8'h06, 16'h1F90, 16'h0050, 1'b0}));

        // UDP then ICMP back to back
        mk_frame(16'h0800, 8'h45, 8'd17, 32'h0A010203, 32'hAC100001, 16'h0035, 16'hC350, 14);
        send_frame();
        chk("udp_ports_lit", 128'({o_src_port, o_dst_port}), 128'({16'h0035, 16'hC350}));
        mk_frame(16'h0800, 8'h45, 8'd1, 32'h01020304, 32'h05060708, 16'h1234, 16'h5678, 12);
        send_frame();
        chk("icmp_lit", 128'({o_protocol, o_src_port, o_dst_port, o_hdr_err}),
            128'({8'h01, 16'h0, 16'h0, 1'b0}));

        // non-IPv4, then bad IHL, then exactly 10 words
        mk_frame(16'h86DD, 8'h60, 8'd6, 32'h11111111, 32'h22222222, 16'h0001, 16'h0002, 12);
        send_frame();
        chk("ipv6_err_lit", 128'(o_hdr_err), 128'(1));
        mk_frame(16'h0800, 8'h46, 8'd17, 32'h33333333, 32'h44444444, 16'h0003, 16'h0004, 11);
        send_frame();
        mk_frame(16'h0800, 8'h45, 8'd6, 32'h55555555, 32'h66666666, 16'h0005, 16'h0006, 10);
        send_frame();

        // runts: tlast on w6, then a single-word frame, then a clean frame
        mk_frame(16'h0800, 8'h45, 8'd6, 32'hC0A80002, 32'h0A000009, 16'h0100, 16'h0200, 7);
        send_frame();
        chk("runt_lit", 128'({o_src_ip, o_hdr_err}), 128'({32'hC0A80000, 1'b1}));
        mk_frame(16'h0800, 8'h45, 8'd6, 32'h77777777, 32'h88888888, 16'h0007, 16'h0008, 1);
        send_frame();
        mk_frame(16'h0800, 8'h45, 8'd17, 32'hC0A80003, 32'h0A00000A, 16'h0300, 16'h0400, 13);
        send_frame();

        // backpressure: result held 20 cycles, next w0 stalls
        i_tuple_ready = 1'b0;
        mk_frame(16'h0800, 8'h45, 8'd6, 32'hDEADBEEF, 32'hCAFEF00D, 16'hAAAA, 16'hBBBB, 12);
        send_frame();
        mk_frame(16'h0800, 8'h45, 8'd17, 32'h01010101, 32'h02020202, 16'h0101, 16'h0202, 11);
        i_rxd_tvalid = 1'b1;
        i_rxd_tdata  = fw[0];
        i_rxd_tlast  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1 chk("stall_w0", 128'(o_rxd_tready), 128'(0));
            @(negedge clk);
        end
        i_tuple_ready = 1'b1;
        #1 chk("release_w0", 128'(o_rxd_tready), 128'(1));
        send_frame();

        // reset with a result pending
        i_tuple_ready = 1'b0;
        mk_frame(16'h0800, 8'h45, 8'd6, 32'h0A0B0C0D, 32'h01020304, 16'h4444, 16'h5555, 10);
        send_frame();
        do_reset();
        i_tuple_ready = 1'b1;

        // reset while w7 is on the bus
        mk_frame(16'h0800, 8'h45, 8'd6, 32'h0B0B0B0B, 32'h0C0C0C0C, 16'h0009, 16'h000A, 12);
        for (int w = 0; w < 7; w++) send_word(fw[w], 1'b0);
        i_rxd_tdata = fw[7];
        do_reset();

        mk_frame(16'h0800, 8'h45, 8'd6, 32'hC0A8010A, 32'h0A000005, 16'h1F90, 16'h0050, 16);
        send_frame();
        chk("post_reset_lit", 128'({o_src_ip, o_dst_ip, o_src_port, o_dst_port, o_hdr_err}),
            128'({32'hC0A8010A, 32'h0A000005, 16'h1F90, 16'h0050, 1'b0}));

        repeat (5) @(negedge clk);
        chk("results_drained", 128'(expq.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
